// File: rtl/player_input_pkg.sv
// Shared key codes, bullet FSM encoding and clamp/colour helpers for player_input_ctrl.
package player_input_pkg;

    localparam logic [7:0] KEY_W     = 8'h77;
    localparam logic [7:0] KEY_A     = 8'h61;
    localparam logic [7:0] KEY_S     = 8'h73;
    localparam logic [7:0] KEY_D     = 8'h64;
    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_C     = 8'h63;
    localparam logic [7:0] KEY_R     = 8'h72;

    localparam logic [15:0] BULLET_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1
    } bullet_fsm_t;

    // Signed 10-bit intermediate so a step past either bound clamps instead of wrapping.
    function automatic logic [7:0] step_axis(input logic [7:0]        v,
                                             input logic signed [1:0] dir,
                                             input logic [7:0]        step,
                                             input logic [7:0]        lo,
                                             input logic [7:0]        hi);
        logic signed [9:0] s;
        s = $signed({2'b00, v});
        if (dir == 2'sd1)
            s = s + $signed({2'b00, step});
        else if (dir == -2'sd1)
            s = s - $signed({2'b00, step});
        if (s < $signed({2'b00, lo}))
            return lo;
        if (s > $signed({2'b00, hi}))
            return hi;
        return s[7:0];
    endfunction

    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

endpackage

// File: rtl/player_input_ctrl_key_decoder.sv
// Combinational ASCII key decode; letters are matched case-insensitively.
module key_decoder
    import player_input_pkg::*;
(
    input  logic [7:0]        rx_data,
    output logic signed [1:0] dx,
    output logic signed [1:0] dy,
    output logic              fire,
    output logic              color,
    output logic              rst,
    output logic              recognised
);

    logic [7:0] lc;

    always_comb begin
        lc = rx_data;
        if (rx_data >= 8'h41 && rx_data <= 8'h5A)
            lc = rx_data | 8'h20;

        dx         = 2'sd0;
        dy         = 2'sd0;
        fire       = 1'b0;
        color      = 1'b0;
        rst        = 1'b0;
        recognised = 1'b1;
        case (lc)
            KEY_W:     dy    = -2'sd1;
            KEY_S:     dy    = 2'sd1;
            KEY_A:     dx    = -2'sd1;
            KEY_D:     dx    = 2'sd1;
            KEY_SPACE: fire  = 1'b1;
            KEY_C:     color = 1'b1;
            KEY_R:     rst   = 1'b1;
            default:   recognised = 1'b0;
        endcase
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Latches decoded keys between frames and applies them on frame_tick; owns player, bullet FSM, shots, colour.
// Optional key echo to a UART transmitter is enabled by defining PLAYER_INPUT_ECHO_EN.
module player_input_ctrl
    import player_input_pkg::*;
#(
    parameter logic [7:0] X_MIN       = 8'd0,
    parameter logic [7:0] X_MAX       = 8'd159,
    parameter logic [7:0] Y_MIN       = 8'd0,
    parameter logic [7:0] Y_MAX       = 8'd119,
    parameter logic [7:0] X_INIT      = 8'd80,
    parameter logic [7:0] Y_INIT      = 8'd100,
    parameter logic [7:0] STEP        = 8'd4,
    parameter logic [7:0] BULLET_STEP = 8'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_tick,
    output logic [15:0] playerPos,
    output logic [15:0] bulletPos,
    output logic [2:0]  bulletColor,
    output logic [31:0] state
`ifdef PLAYER_INPUT_ECHO_EN
    ,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy
`endif
);

    logic signed [1:0] key_dx, key_dy;
    logic              key_fire, key_color, key_rst, key_ok;

    key_decoder u_key_decoder (
        .rx_data    (rx_data),
        .dx         (key_dx),
        .dy         (key_dy),
        .fire       (key_fire),
        .color      (key_color),
        .rst        (key_rst),
        .recognised (key_ok)
    );

    logic signed [1:0] pend_dx, pend_dy;
    logic              pend_fire, pend_color, pend_reset;
    logic [7:0]        player_x, player_y;
    logic [15:0]       bullet_pos;
    logic [15:0]       shots;
    logic [2:0]        color;
    bullet_fsm_t       fsm;
    logic              accept;

    assign accept      = rx_valid && key_ok;
    assign playerPos   = {player_x, player_y};
    assign bulletPos   = bullet_pos;
    assign bulletColor = color;
    assign state       = {shots, 14'b0, fsm};

    always_ff @(posedge clk) begin
        if (!reset) begin
            player_x   <= X_INIT;
            player_y   <= Y_INIT;
            bullet_pos <= BULLET_NONE;
            shots      <= 16'd0;
            color      <= 3'd1;
            fsm        <= IDLE;
            pend_dx    <= 2'sd0;
            pend_dy    <= 2'sd0;
            pend_fire  <= 1'b0;
            pend_color <= 1'b0;
            pend_reset <= 1'b0;
        end else begin
            if (frame_tick) begin
                if (pend_reset) begin
                    player_x   <= X_INIT;
                    player_y   <= Y_INIT;
                    bullet_pos <= BULLET_NONE;
                    fsm        <= IDLE;
                end else begin
                    player_x <= step_axis(player_x, pend_dx, STEP, X_MIN, X_MAX);
                    player_y <= step_axis(player_y, pend_dy, STEP, Y_MIN, Y_MAX);
                    case (fsm)
                        IDLE: begin
                            // Bullet launches from where the player stood before this tick's move.
                            if (pend_fire) begin
                                bullet_pos <= {player_x, player_y};
                                fsm        <= FLY;
                                if (shots != 16'hFFFF)
                                    shots <= shots + 16'd1;
                            end
                        end
                        FLY: begin
                            if ({1'b0, bullet_pos[7:0]} < ({1'b0, Y_MIN} + {1'b0, BULLET_STEP})) begin
                                bullet_pos <= BULLET_NONE;
                                fsm        <= IDLE;
                            end else begin
                                bullet_pos[7:0] <= bullet_pos[7:0] - BULLET_STEP;
                            end
                        end
                        default: begin
                            bullet_pos <= BULLET_NONE;
                            fsm        <= IDLE;
                        end
                    endcase
                end
                if (pend_color)
                    color <= next_color(color);
                pend_dx    <= 2'sd0;
                pend_dy    <= 2'sd0;
                pend_fire  <= 1'b0;
                pend_color <= 1'b0;
                pend_reset <= 1'b0;
            end
            // A byte coinciding with the tick lands after the clear, so it belongs to the next frame.
            if (accept) begin
                if (key_dx != 2'sd0) pend_dx <= key_dx;
                if (key_dy != 2'sd0) pend_dy <= key_dy;
                if (key_fire)  pend_fire  <= 1'b1;
                if (key_color) pend_color <= 1'b1;
                if (key_rst)   pend_reset <= 1'b1;
            end
        end
    end

`ifdef PLAYER_INPUT_ECHO_EN
    logic [7:0] echo_buf;
    logic       echo_full;
    logic [7:0] echo_cand;
    logic       echo_has;

    assign echo_cand = accept ? rx_data : echo_buf;
    assign echo_has  = accept || echo_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            echo_buf  <= 8'd0;
            echo_full <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (echo_has && !tx_busy) begin
                tx_start  <= 1'b1;
                tx_data   <= echo_cand;
                echo_full <= 1'b0;
            end else if (echo_has) begin
                echo_buf  <= echo_cand;
                echo_full <= 1'b1;
            end
        end
    end
`endif

endmodule
